// File: rtl/uart_rx_if.sv
//------------------------------------------------------------------------------
// Module      : uart_rx_if
// Description : Signal bundle for the UART receiver. It carries the serial line
//               into the receiver and the received byte and status strobes out.
//               - rxd       : serial line, idle high
//               - data      : last correctly received byte
//               - valid     : one-cycle strobe, new byte on data
//               - frame_err : one-cycle strobe, bad stop bit
//               - busy      : frame in progress
//               The receiver uses the slave modport. The line driver and the
//               consumer use the master modport.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output rxd,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rxd,
        output data,
        output valid,
        output frame_err,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module      : uart_rx
// Description : 8N1 UART receiver. A start edge is validated at the centre of
//               the start bit. Each data bit is then sampled at its centre, and
//               the stop bit is checked at its centre.
// Ports       : clk - clock, rising edge
//               rst - asynchronous active-high reset
//               bus - uart_rx_if.slave, carrying rxd in and
//                     data/valid/frame_err/busy out
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
    parameter int F_CLK = 50000000,
    parameter int BAUD  = 38400
) (
    input  wire        clk,
    input  wire        rst,
    uart_rx_if.slave   bus
);

    localparam int NB = F_CLK / BAUD;           // clocks per bit
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] c_half_m1 = CW'(NB / 2 - 1);
    localparam logic [CW-1:0] c_bit_m1  = CW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t          r_state, w_state_n;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [2:0]      r_idx, w_idx_n;
    logic [7:0]      r_sr, w_sr_n;
    logic [7:0]      r_data, w_data_n;
    logic            r_valid, w_valid_n;
    logic            r_ferr, w_ferr_n;
    logic            w_rs;

    // The synchronizer resets to the idle level, so reset release on an idle
    // line cannot look like a start edge.
    assign w_rs = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_sr    <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], bus.rxd};
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_sr    <= w_sr_n;
            r_data  <= w_data_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CW'(1);
        w_idx_n   = r_idx;
        w_sr_n    = r_sr;
        w_data_n  = r_data;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (!w_rs) begin
                    w_state_n = S_START;
                end
            end
            S_START: begin
                // Half a bit after the falling edge: the line must still be
                // low. Otherwise the edge was a glitch.
                if (r_cnt == c_half_m1) begin
                    w_cnt_n   = '0;
                    w_idx_n   = 3'd0;
                    w_state_n = w_rs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_m1) begin
                    w_cnt_n = '0;
                    // LSB arrives first, so shifting in from the top leaves
                    // the first bit in sr[0] after eight samples.
                    w_sr_n  = {w_rs, r_sr[7:1]};
                    w_idx_n = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == c_bit_m1) begin
                    w_cnt_n = '0;
                    if (w_rs) begin
                        w_data_n  = r_sr;
                        w_valid_n = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_ferr_n  = 1'b1;
                        w_state_n = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Wait out a break: a low line here is not a new start bit.
                w_cnt_n = '0;
                if (w_rs) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_cnt_n   = '0;
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx.
//               - Instance A uses the default parameters (NB = 1302).
//               - Instance B uses F_CLK = 1000 and BAUD = 100 (NB = 10).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    localparam int NB_A = 1302;
    localparam int NB_B = 10;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int checks = 0;
    int errors = 0;

    uart_rx_if bus_a ();
    uart_rx_if bus_b ();

    uart_rx dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    uart_rx #(
        .F_CLK (1000),
        .BAUD  (100)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    always #10 clk = ~clk;

    // Monitors: record received bytes, count strobes, and flag rule breaks.
    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    int         vcnt_a = 0, fcnt_a = 0, vcnt_b = 0, fcnt_b = 0;
    bit         both_a = 0, both_b = 0, dchg_a = 0, dchg_b = 0;
    logic [7:0] pdata_a = 8'h00, pdata_b = 8'h00;

    always @(negedge clk) begin
        if (bus_a.valid) begin
            vcnt_a++;
            rx_a.push_back(bus_a.data);
        end
        if (bus_a.frame_err) fcnt_a++;
        if (bus_a.valid && bus_a.frame_err) both_a = 1;
        if (!rst_a && bus_a.data !== pdata_a && !bus_a.valid) dchg_a = 1;
        pdata_a = bus_a.data;

        if (bus_b.valid) begin
            vcnt_b++;
            rx_b.push_back(bus_b.data);
        end
        if (bus_b.frame_err) fcnt_b++;
        if (bus_b.valid && bus_b.frame_err) both_b = 1;
        if (!rst_b && bus_b.data !== pdata_b && !bus_b.valid) dchg_b = 1;
        pdata_b = bus_b.data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rxd(input bit sel, input logic v);
        if (sel) bus_b.rxd = v;
        else     bus_a.rxd = v;
    endtask

    // One 8N1 frame; the start bit begins 1 ns after the next rising edge.
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int nb);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            set_rxd(sel, f[i]);
            repeat (nb) @(posedge clk);
            #1;
        end
    endtask

    int cyc;

    initial begin
        bus_a.rxd = 1'b1;
        bus_b.rxd = 1'b1;
        wait_cycles(3);
        check("rst_data_a",  {24'd0, bus_a.data}, 32'h00);
        check("rst_valid_a", {31'd0, bus_a.valid}, 32'd0);
        check("rst_ferr_a",  {31'd0, bus_a.frame_err}, 32'd0);
        check("rst_busy_a",  {31'd0, bus_a.busy}, 32'd0);
        check("rst_busy_b",  {31'd0, bus_b.busy}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_cycles(10);
        check("no_false_start", {30'd0, bus_a.busy, bus_b.busy}, 32'd0);

        // ---------------- Instance A: default rate ----------------
        send_frame(0, 8'h55, 1'b1, NB_A);
        wait_cycles(5);
        check("a55_count", vcnt_a, 32'd1);
        check("a55_data",  {24'd0, rx_a[0]}, 32'h55);
        check("a55_ferr",  fcnt_a, 32'd0);
        check("a55_busy",  {31'd0, bus_a.busy}, 32'd0);

        // A 10-cycle (200 ns) glitch is rejected at the half-bit point.
        bus_a.rxd = 1'b0;
        wait_cycles(10);
        bus_a.rxd = 1'b1;
        wait_cycles(100);
        check("glitch_busy_mid", {31'd0, bus_a.busy}, 32'd1);
        wait_cycles(700);
        check("glitch_busy_end", {31'd0, bus_a.busy}, 32'd0);
        check("glitch_valid",    vcnt_a, 32'd1);
        check("glitch_ferr",     fcnt_a, 32'd0);
        check("glitch_data",     {24'd0, bus_a.data}, 32'h55);

        // ---------------- Instance B: NB = 10 ----------------
        send_frame(1, 8'hFF, 1'b1, NB_B);
        send_frame(1, 8'h00, 1'b1, NB_B);
        wait_cycles(5);
        check("b2b_count", vcnt_b, 32'd2);
        check("b2b_ff",    {24'd0, rx_b[0]}, 32'hFF);
        check("b2b_00",    {24'd0, rx_b[1]}, 32'h00);

        // Stop bit low, and the line held low for three bit times in total.
        send_frame(1, 8'hA3, 1'b0, NB_B);
        wait_cycles(15);
        check("ferr_count", fcnt_b, 32'd1);
        check("ferr_novld", vcnt_b, 32'd2);
        check("ferr_data",  {24'd0, bus_b.data}, 32'h00);
        check("ferr_busy",  {31'd0, bus_b.busy}, 32'd1);
        wait_cycles(5);
        bus_b.rxd = 1'b1;
        wait_cycles(10);
        check("ferr_idle", {31'd0, bus_b.busy}, 32'd0);
        send_frame(1, 8'h3C, 1'b1, NB_B);
        wait_cycles(5);
        check("after_ferr_count", vcnt_b, 32'd3);
        check("after_ferr_3c",    {24'd0, rx_b[2]}, 32'h3C);

        // Reset during data bit 4. The bits sent after it are all 1, so the
        // line reads idle once reset is released.
        fork
            send_frame(1, 8'hF0, 1'b1, NB_B);
            begin
                wait_cycles(1);
                wait_cycles(52);
                rst_b = 1'b1;
                #1;
                check("rst_mid_data",  {24'd0, bus_b.data}, 32'h00);
                check("rst_mid_busy",  {31'd0, bus_b.busy}, 32'd0);
                check("rst_mid_valid", {30'd0, bus_b.valid, bus_b.frame_err}, 32'd0);
                #100;
                rst_b = 1'b0;
            end
        join
        wait_cycles(5);
        check("rst_abort_vld",  vcnt_b, 32'd3);
        check("rst_abort_ferr", fcnt_b, 32'd1);
        send_frame(1, 8'h81, 1'b1, NB_B);
        wait_cycles(5);
        check("post_rst_81", {24'd0, rx_b[3]}, 32'h81);

        // Latency: valid is expected 9.5*10 + 3 = 98 edges after the start edge.
        cyc = 0;
        fork
            send_frame(1, 8'hC6, 1'b1, NB_B);
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (bus_b.valid) break;
                end
            end
        join
        wait_cycles(5);
        check("lat_cycles", cyc, 32'd98);
        check("lat_c6",     {24'd0, rx_b[4]}, 32'hC6);
        check("lat_count",  vcnt_b, 32'd5);

        check("excl_a",  {31'd0, both_a}, 32'd0);
        check("excl_b",  {31'd0, both_b}, 32'd0);
        check("dchg_a",  {31'd0, dchg_a}, 32'd0);
        check("dchg_b",  {31'd0, dchg_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter F_CLK, default 50000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 38400, meaning the serial bit rate.
REQ-003 The module SHALL define localparam NB = F_CLK/BAUD (integer divide; 1302 at defaults), meaning clocks per bit.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port rxd, input, 1 bit: the asynchronous serial line, idle high.
REQ-007 The module SHALL have port data, output, 8 bits: the last correctly received byte.
REQ-008 The module SHALL have port valid, output, 1 bit: a one-cycle strobe marking a new byte on data.
REQ-009 The module SHALL have port frame_err, output, 1 bit: a one-cycle strobe marking a bad stop bit.
REQ-010 The module SHALL have port busy, output, 1 bit: high while a frame is in progress (state other than IDLE).

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all logic below SHALL use the synchronized signal rs only.
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 In IDLE, rs = 0 SHALL move the FSM to START and clear the bit-period counter cnt.
REQ-015 In START, when cnt = NB/2-1, rs = 0 SHALL move the FSM to DATA and rs = 1 SHALL return it to IDLE (glitch reject) with no strobe.
REQ-016 In DATA, each bit SHALL be sampled when cnt = NB-1, with cnt restarting at 0; the sample SHALL shift into shift register sr from the MSB side, so the first bit ends at sr[0].
REQ-017 The 3-bit bit index SHALL count 0..7; the FSM SHALL move to STOP after the sample with index 7.
REQ-018 In STOP, when cnt = NB-1, rs = 1 SHALL load data with sr, pulse valid for 1 cycle and go to IDLE.
REQ-019 In STOP, when cnt = NB-1, rs = 0 SHALL pulse frame_err for 1 cycle, leave data unchanged and go to WAIT_IDLE.
REQ-020 In WAIT_IDLE, rs = 1 SHALL move the FSM to IDLE; no start SHALL be detected until then (break condition).
REQ-021 valid and frame_err SHALL never be high in the same cycle.
REQ-022 data SHALL change only in the cycle in which valid is high.
REQ-023 Latency SHALL be: valid rises on the clk edge after the stop-bit centre sample (about 9.5*NB + 3 clk after the start falling edge on rxd, including the synchronizer).
REQ-024 cnt SHALL be $clog2(NB) bits wide; it SHALL not wrap within a bit period.
REQ-025 In IDLE and WAIT_IDLE, cnt SHALL be held at 0.
REQ-026 A start edge SHALL be accepted in the cycle following the valid strobe, so back-to-back frames with a single stop bit are received.

Reset
REQ-027 rst = 1 SHALL force asynchronously: state IDLE, cnt = 0, index = 0, sr = 0, data = 8'h00, valid = 0, frame_err = 0, busy = 0, and both synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-029 After reset release with rxd = 1, no false start SHALL occur.
REQ-030 After reset release with rxd = 0, the module SHALL treat this as a start edge and validate it per REQ-015.

Verification
REQ-031 At defaults, send 0x55 at 26 us/bit -> exactly one valid pulse, data = 8'h55, frame_err never high, busy low after the stop bit.
REQ-032 Send start bit then line high for 234 us -> valid with data = 8'hFF; then send 0x00 back-to-back -> second valid with data = 8'h00.
REQ-033 Drive a 200 ns low glitch on an idle line -> FSM returns to IDLE at the half-bit point, no valid, no frame_err, data unchanged.
REQ-034 Send 0xA3 with stop bit = 0, holding low for 3 bit times -> one frame_err pulse, data keeps its previous value, busy high until the line returns high, then a following 0x3C frame is received correctly.
REQ-035 Assert rst for 100 ns during data bit 4 of a frame -> all outputs = 0 immediately; after release, a clean 0x81 frame -> valid with data = 8'h81.
REQ-036 Set F_CLK = 1000 and BAUD = 100 (NB = 10) and send 0xC6 -> valid asserted 9.5*NB + 3 clk (+/-1) after the start falling edge, data = 8'hC6.
